// File: rtl/perf_pkg.sv
// Shared types and overflow-flag bit positions for the multi-channel performance monitor.
package perf_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } perf_state_e;

   localparam int OVF_TOTAL   = 0;
   localparam int OVF_ANY     = 1;
   localparam int OVF_IDLE    = 2;
   localparam int OVF_CH_BASE = 3;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with synchronous load and a sticky overflow flag.
// load has priority over inc and clears the flag. An increment at all-ones holds the count and sets ovf.
module perf_sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic             ovf
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;

   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      if (load) begin
         count_d = load_val;
         ovf_d   = 1'b0;
      end else if (inc) begin
         if (&count_q) ovf_d   = 1'b1;
         else          count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count = count_q;
   assign ovf   = ovf_q;

endmodule

// File: rtl/perf_mc.sv
// Multi-channel window performance monitor: live saturating counters, snapshotted at window end.
// Optional per-channel longest-busy-run tracking is enabled with `define PERF_MAX_RUN_EN.
//
// state   | meaning
// IDLE    | no window open, snapshot outputs held
// MEASURE | window open, live counters accumulating
module perf_mc
   import perf_pkg::*;
#(
   parameter int NUM_CH        = 4,
   parameter int COUNTER_WIDTH = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start_pulse,
   input  logic                            done_pulse,
   input  logic [NUM_CH-1:0]               busy_signal,
   output logic                            measuring,
   output logic [COUNTER_WIDTH-1:0]        total_cycles_count,
   output logic [NUM_CH*COUNTER_WIDTH-1:0] active_cycles_count,
   output logic [COUNTER_WIDTH-1:0]        any_active_count,
   output logic [COUNTER_WIDTH-1:0]        idle_cycles_count,
   output logic [NUM_CH+2:0]               overflow_flags,
   output logic [NUM_CH*COUNTER_WIDTH-1:0] max_run_count,
   output logic                            measurement_done
);

   localparam int W  = COUNTER_WIDTH;
   localparam int NF = NUM_CH + 3;

   perf_state_e state_q, state_d;
   logic        in_meas, count_en, snap_en, any_b;

   logic [W-1:0]        tot_live, any_live, idle_live;
   logic [NUM_CH*W-1:0] act_live;
   logic [NF-1:0]       ovf_live;

   logic [W-1:0]        tot_q, any_q, idle_q;
   logic [NUM_CH*W-1:0] act_q;
   logic [NF-1:0]       ovf_q;
   logic                done_q;

   assign in_meas  = (state_q == MEASURE);
   // The start cycle is loaded rather than counted; the done cycle is excluded.
   assign count_en = in_meas & ~done_pulse & ~start_pulse;
   assign snap_en  = in_meas & done_pulse;
   assign any_b    = |busy_signal;

   always_comb begin
      state_d = state_q;
      if (start_pulse)     state_d = MEASURE;
      else if (done_pulse) state_d = IDLE;
   end

   perf_sat_counter #(.WIDTH(W)) u_total (
      .clk(clk), .rst(rst), .load(start_pulse), .load_val({{(W-1){1'b0}}, 1'b1}),
      .inc(count_en), .count(tot_live), .ovf(ovf_live[OVF_TOTAL]));

   perf_sat_counter #(.WIDTH(W)) u_any (
      .clk(clk), .rst(rst), .load(start_pulse), .load_val({{(W-1){1'b0}}, any_b}),
      .inc(count_en & any_b), .count(any_live), .ovf(ovf_live[OVF_ANY]));

   perf_sat_counter #(.WIDTH(W)) u_idle (
      .clk(clk), .rst(rst), .load(start_pulse), .load_val({{(W-1){1'b0}}, ~any_b}),
      .inc(count_en & ~any_b), .count(idle_live), .ovf(ovf_live[OVF_IDLE]));

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      perf_sat_counter #(.WIDTH(W)) u_act (
         .clk(clk), .rst(rst), .load(start_pulse),
         .load_val({{(W-1){1'b0}}, busy_signal[i]}),
         .inc(count_en & busy_signal[i]),
         .count(act_live[i*W +: W]), .ovf(ovf_live[OVF_CH_BASE+i]));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
         tot_q   <= '0;
         any_q   <= '0;
         idle_q  <= '0;
         act_q   <= '0;
         ovf_q   <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= snap_en;
         if (snap_en) begin
            tot_q  <= tot_live;
            any_q  <= any_live;
            idle_q <= idle_live;
            act_q  <= act_live;
            ovf_q  <= ovf_live;
         end
      end
   end

   assign measuring           = in_meas;
   assign measurement_done    = done_q;
   assign total_cycles_count  = tot_q;
   assign any_active_count    = any_q;
   assign idle_cycles_count   = idle_q;
   assign active_cycles_count = act_q;
   assign overflow_flags      = ovf_q;

`ifdef PERF_MAX_RUN_EN
   for (genvar i = 0; i < NUM_CH; i++) begin : g_run
      logic [W-1:0] run_cnt, run_cand, max_q, max_snap_q;
      logic         run_ovf;

      // Run restarts at the window start and whenever the channel goes idle.
      perf_sat_counter #(.WIDTH(W)) u_run (
         .clk(clk), .rst(rst),
         .load(start_pulse | (count_en & ~busy_signal[i])),
         .load_val({{(W-1){1'b0}}, start_pulse & busy_signal[i]}),
         .inc(count_en & busy_signal[i]),
         .count(run_cnt), .ovf(run_ovf));

      assign run_cand = (run_ovf | (&run_cnt)) ? run_cnt : run_cnt + 1'b1;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            max_q      <= '0;
            max_snap_q <= '0;
         end else begin
            if (start_pulse)
               max_q <= {{(W-1){1'b0}}, busy_signal[i]};
            else if (count_en & busy_signal[i] & (run_cand > max_q))
               max_q <= run_cand;
            if (snap_en) max_snap_q <= max_q;
         end
      end

      assign max_run_count[i*W +: W] = max_snap_q;
   end
`else
   assign max_run_count = '0;
`endif

endmodule

// File: tb/tb_perf_mc.sv
// Bench for perf_mc: a 32-bit and an 8-bit instance share stimulus and are checked against a window-replay model.
module tb_perf_mc;

   localparam int NCH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_pulse = 1'b0;
   logic done_pulse  = 1'b0;
   logic [NCH-1:0] busy_signal = '0;

   always #5 clk = ~clk;

   logic        a_meas, a_done, b_meas, b_done;
   logic [31:0] a_total, a_any, a_idle;
   logic [127:0] a_act, a_maxr;
   logic [6:0]  a_flags, b_flags;
   logic [7:0]  b_total, b_any, b_idle;
   logic [31:0] b_act, b_maxr;

   perf_mc #(.NUM_CH(NCH), .COUNTER_WIDTH(32)) dut_a (
      .clk(clk), .rst(rst), .start_pulse(start_pulse), .done_pulse(done_pulse),
      .busy_signal(busy_signal), .measuring(a_meas), .total_cycles_count(a_total),
      .active_cycles_count(a_act), .any_active_count(a_any), .idle_cycles_count(a_idle),
      .overflow_flags(a_flags), .max_run_count(a_maxr), .measurement_done(a_done));

   perf_mc #(.NUM_CH(NCH), .COUNTER_WIDTH(8)) dut_b (
      .clk(clk), .rst(rst), .start_pulse(start_pulse), .done_pulse(done_pulse),
      .busy_signal(busy_signal), .measuring(b_meas), .total_cycles_count(b_total),
      .active_cycles_count(b_act), .any_active_count(b_any), .idle_cycles_count(b_idle),
      .overflow_flags(b_flags), .max_run_count(b_maxr), .measurement_done(b_done));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: replay the busy samples of the open window, derive raw (unsaturated) results at done.
   bit             in_win = 1'b0;
   bit             e_done = 1'b0;
   logic [NCH-1:0] win_q[$];
   longint unsigned r_total = 0, r_any = 0, r_idle = 0;
   longint unsigned r_act[NCH] = '{default: 0};
   longint unsigned r_max[NCH] = '{default: 0};

   task automatic take_snapshot();
      longint unsigned run[NCH];
      r_total = win_q.size();
      r_any   = 0;
      for (int i = 0; i < NCH; i++) begin
         r_act[i] = 0; r_max[i] = 0; run[i] = 0;
      end
      foreach (win_q[k]) begin
         if (win_q[k] != 0) r_any++;
         for (int i = 0; i < NCH; i++) begin
            if (win_q[k][i]) begin
               r_act[i]++; run[i]++;
               if (run[i] > r_max[i]) r_max[i] = run[i];
            end else run[i] = 0;
         end
      end
      r_idle = r_total - r_any;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         in_win = 1'b0; e_done = 1'b0; win_q.delete();
         r_total = 0; r_any = 0; r_idle = 0;
         for (int i = 0; i < NCH; i++) begin r_act[i] = 0; r_max[i] = 0; end
      end else begin
         e_done = 1'b0;
         if (in_win && done_pulse) begin
            take_snapshot();
            e_done = 1'b1;
         end
         if (start_pulse) begin
            win_q.delete();
            win_q.push_back(busy_signal);
            in_win = 1'b1;
         end else if (in_win && done_pulse) in_win = 1'b0;
         else if (in_win) win_q.push_back(busy_signal);
      end
   end

   function automatic longint unsigned sat(input longint unsigned v, input int w);
      longint unsigned m = (64'd1 << w) - 1;
      return (v > m) ? m : v;
   endfunction

   task automatic check_dut(input string tag, input int w, input logic meas, input logic done,
                            input logic [63:0] tot, input logic [63:0] anyc, input logic [63:0] idl,
                            input logic [6:0] flg, input logic [63:0] act[NCH], input logic [63:0] mx[NCH]);
      longint unsigned m = (64'd1 << w) - 1;
      logic [6:0] ef;
      ef[0] = r_total > m;
      ef[1] = r_any > m;
      ef[2] = r_idle > m;
      for (int i = 0; i < NCH; i++) ef[3+i] = r_act[i] > m;
      chk({tag, "_measuring"}, 64'(meas), 64'(in_win));
      chk({tag, "_done"}, 64'(done), 64'(e_done));
      chk({tag, "_total"}, tot, sat(r_total, w));
      chk({tag, "_any"}, anyc, sat(r_any, w));
      chk({tag, "_idle"}, idl, sat(r_idle, w));
      chk({tag, "_flags"}, 64'(flg), 64'(ef));
      for (int i = 0; i < NCH; i++) begin
         chk($sformatf("%s_active%0d", tag, i), act[i], sat(r_act[i], w));
`ifdef PERF_MAX_RUN_EN
         chk($sformatf("%s_maxrun%0d", tag, i), mx[i], sat(r_max[i], w));
`else
         chk($sformatf("%s_maxrun%0d", tag, i), mx[i], 64'd0);
`endif
      end
   endtask

   always @(negedge clk) begin
      logic [63:0] aa[NCH], am[NCH], ba[NCH], bm[NCH];
      for (int i = 0; i < NCH; i++) begin
         aa[i] = 64'(a_act[i*32 +: 32]);  am[i] = 64'(a_maxr[i*32 +: 32]);
         ba[i] = 64'(b_act[i*8 +: 8]);    bm[i] = 64'(b_maxr[i*8 +: 8]);
      end
      check_dut("A", 32, a_meas, a_done, 64'(a_total), 64'(a_any), 64'(a_idle), a_flags, aa, am);
      check_dut("B", 8, b_meas, b_done, 64'(b_total), 64'(b_any), 64'(b_idle), b_flags, ba, bm);
   end

   task automatic step(input bit s, input bit d, input logic [NCH-1:0] b);
      start_pulse = s; done_pulse = d; busy_signal = b;
      @(posedge clk); #1;
   endtask

   logic [9:0] pat;

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_total", 64'(a_total), 64'd0);
      chk("reset_flags", 64'(a_flags), 64'd0);
      chk("reset_measuring", 64'(a_meas), 64'd0);

      // all busy, 100-cycle window
      step(1, 0, 4'hF);
      repeat (99) step(0, 0, 4'hF);
      step(0, 1, 4'hF);
      chk("t1_done", 64'(a_done), 64'd1);
      chk("t1_total", 64'(a_total), 64'd100);
      chk("t1_act3", 64'(a_act[127:96]), 64'd100);
      chk("t1_any", 64'(a_any), 64'd100);
      chk("t1_idle", 64'(a_idle), 64'd0);
      chk("t1_flags", 64'(a_flags), 64'd0);
      step(0, 0, 4'h0);
      chk("t1_done_pulse_len", 64'(a_done), 64'd0);

      // channel 0 toggles, starting at 0
      for (int k = 0; k < 50; k++) step(k == 0, 0, {3'b000, k[0]});
      step(0, 1, 4'h0);
      chk("t2_total", 64'(a_total), 64'd50);
      chk("t2_act0", 64'(a_act[31:0]), 64'd25);
      chk("t2_act1", 64'(a_act[63:32]), 64'd0);
      chk("t2_any", 64'(a_any), 64'd25);
      chk("t2_idle", 64'(a_idle), 64'd25);

      // back-to-back windows: done and start together
      step(1, 0, 4'h0);
      repeat (9) step(0, 0, 4'h0);
      step(1, 1, 4'h0);
      chk("t3_total", 64'(a_total), 64'd10);
      chk("t3_idle", 64'(a_idle), 64'd10);
      chk("t3_measuring", 64'(a_meas), 64'd1);
      repeat (4) step(0, 0, 4'hF);
      step(0, 1, 4'h0);
      chk("t3b_total", 64'(a_total), 64'd5);
      chk("t3b_any", 64'(a_any), 64'd4);
      chk("t3b_idle", 64'(a_idle), 64'd1);

      // 8-bit instance saturates
      step(1, 0, 4'h4);
      repeat (299) step(0, 0, 4'h4);
      step(0, 1, 4'h0);
      chk("t4_b_total", 64'(b_total), 64'd255);
      chk("t4_b_act2", 64'(b_act[23:16]), 64'd255);
      chk("t4_b_flags", 64'(b_flags), 64'h23);
      chk("t4_a_total", 64'(a_total), 64'd300);
      step(1, 0, 4'h0);
      step(0, 0, 4'h0);
      step(0, 1, 4'h0);
      chk("t4_b_flags_cleared", 64'(b_flags), 64'd0);
      chk("t4_b_total_short", 64'(b_total), 64'd2);

      // protocol corners
      step(0, 1, 4'hF);
      chk("t5_idle_done_pulse", 64'(a_done), 64'd0);
      chk("t5_idle_done_total", 64'(a_total), 64'd2);
      step(1, 0, 4'hF);
      repeat (4) step(0, 0, 4'hF);
      step(1, 0, 4'h0);
      chk("t5_restart_total_held", 64'(a_total), 64'd2);
      chk("t5_restart_no_pulse", 64'(a_done), 64'd0);
      repeat (2) step(0, 0, 4'hF);
      step(0, 1, 4'h0);
      chk("t5_restart_total", 64'(a_total), 64'd3);
      chk("t5_restart_any", 64'(a_any), 64'd2);
      step(1, 0, 4'hF);
      repeat (3) step(0, 0, 4'hF);
      start_pulse = 0; done_pulse = 0; busy_signal = 0;
      rst = 1'b1;
      #1;
      chk("t5_rst_total", 64'(a_total), 64'd0);
      chk("t5_rst_measuring", 64'(a_meas), 64'd0);
      chk("t5_rst_act", 64'(a_act), 64'd0);
      @(posedge clk); #1 rst = 1'b0;

      // run-length pattern on channel 1
      pat = 10'b0111110111;
      for (int k = 0; k < 10; k++) step(k == 0, 0, {2'b00, pat[k], 1'b0});
      step(0, 1, 4'h0);
      chk("t6_total", 64'(a_total), 64'd10);
      chk("t6_act1", 64'(a_act[63:32]), 64'd8);
`ifdef PERF_MAX_RUN_EN
      chk("t6_maxrun1", 64'(a_maxr[63:32]), 64'd5);
`else
      chk("t6_maxrun1", 64'(a_maxr[63:32]), 64'd0);
`endif

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 999) < 3) begin
            start_pulse = 0; done_pulse = 0;
            rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
         end else begin
            logic [NCH-1:0] b;
            b = ($urandom_range(0, 3) == 0) ? 4'hF : NCH'($urandom_range(0, 15));
            step($urandom_range(0, 24) == 0, $urandom_range(0, 14) == 0, b);
         end
      end
      step(0, 1, 4'h0);
      step(0, 0, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
